// File: rtl/sad_pkg.sv
// Shared definitions for the custom SAD instruction datapath (EX3 lane generator,
// EX4 min tracker, SAD/min register writeback).
package sad_pkg;

  localparam int NUM_LANES        = 16;
  localparam int DATA_W_DEFAULT   = 32;
  localparam int MAX_ROWS_DEFAULT = 16;

  localparam logic [DATA_W_DEFAULT-1:0] SAD_INIT = '1;

  typedef enum logic {
    IDLE,
    ACCUM
  } sad_state_e;

endpackage

// File: rtl/sad_adder_tree16.sv
// Stage A of the EX4 SAD consumer: balanced 16-lane unsigned adder tree (mod 2^DATA_W)
// followed by the stage A register for the row sum and its control/coordinate fields.
module sad_adder_tree16
  import sad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             valid_i,
  input  logic                             start_i,
  input  logic                             last_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0] lanes_i,
  input  logic [DATA_W-1:0]                outx_i,
  input  logic [DATA_W-1:0]                outy_i,
  output logic                             valid_o,
  output logic                             start_o,
  output logic                             last_o,
  output logic [DATA_W-1:0]                row_sum_o,
  output logic [DATA_W-1:0]                outx_o,
  output logic [DATA_W-1:0]                outy_o
);

  logic [DATA_W-1:0] l1_sum [8];
  logic [DATA_W-1:0] l2_sum [4];
  logic [DATA_W-1:0] l3_sum [2];
  logic [DATA_W-1:0] row_sum_d;

  logic              valid_q, start_q, last_q;
  logic [DATA_W-1:0] row_sum_q, outx_q, outy_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_l1
      assign l1_sum[gi] = lanes_i[2*gi] + lanes_i[2*gi+1];
    end
    for (gi = 0; gi < 4; gi++) begin : g_l2
      assign l2_sum[gi] = l1_sum[2*gi] + l1_sum[2*gi+1];
    end
    for (gi = 0; gi < 2; gi++) begin : g_l3
      assign l3_sum[gi] = l2_sum[2*gi] + l2_sum[2*gi+1];
    end
  endgenerate

  assign row_sum_d = l3_sum[0] + l3_sum[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      row_sum_q <= '0;
      outx_q    <= '0;
      outy_q    <= '0;
    end else begin
      valid_q   <= valid_i;
      start_q   <= start_i;
      last_q    <= last_i;
      row_sum_q <= row_sum_d;
      outx_q    <= outx_i;
      outy_q    <= outy_i;
    end
  end

  assign valid_o   = valid_q;
  assign start_o   = start_q;
  assign last_o    = last_q;
  assign row_sum_o = row_sum_q;
  assign outx_o    = outx_q;
  assign outy_o    = outy_q;

endmodule

// File: rtl/sad_min_tracker_ex4.sv
// EX4 SAD consumer: reduces each 16-lane row, accumulates rows into a window SAD and
// tracks the minimum window SAD with its candidate coordinates.
module sad_min_tracker_ex4
  import sad_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MAX_ROWS = MAX_ROWS_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              sad_valid_EX4,
  input  logic              sad_start_EX4,
  input  logic              sad_last_EX4,
  input  logic              clear_min,
  input  logic [DATA_W-1:0] In1_EX4,
  input  logic [DATA_W-1:0] In2_EX4,
  input  logic [DATA_W-1:0] In3_EX4,
  input  logic [DATA_W-1:0] In4_EX4,
  input  logic [DATA_W-1:0] In5_EX4,
  input  logic [DATA_W-1:0] In6_EX4,
  input  logic [DATA_W-1:0] In7_EX4,
  input  logic [DATA_W-1:0] In8_EX4,
  input  logic [DATA_W-1:0] In9_EX4,
  input  logic [DATA_W-1:0] In10_EX4,
  input  logic [DATA_W-1:0] In11_EX4,
  input  logic [DATA_W-1:0] In12_EX4,
  input  logic [DATA_W-1:0] In13_EX4,
  input  logic [DATA_W-1:0] In14_EX4,
  input  logic [DATA_W-1:0] In15_EX4,
  input  logic [DATA_W-1:0] In16_EX4,
  input  logic [DATA_W-1:0] outx_EX4,
  input  logic [DATA_W-1:0] outy_EX4,
  output logic [DATA_W-1:0] sad_out,
  output logic              sad_done,
  output logic [DATA_W-1:0] min_sad,
  output logic [DATA_W-1:0] best_x,
  output logic [DATA_W-1:0] best_y,
  output logic              better,
  output logic [4:0]        row_count,
  output logic              protocol_err
);

  localparam logic [4:0]        ROW_LIMIT = 5'(MAX_ROWS);
  localparam logic [DATA_W-1:0] MIN_INIT  = '1;

  logic [NUM_LANES-1:0][DATA_W-1:0] lanes;
  logic                             a_valid, a_start, a_last;
  logic [DATA_W-1:0]                a_sum, a_outx, a_outy;

  sad_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [4:0]        row_count_q, row_count_d;
  logic [DATA_W-1:0] sad_out_q, sad_out_d;
  logic              sad_done_q, sad_done_d;
  logic [DATA_W-1:0] min_sad_q, min_sad_d;
  logic [DATA_W-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
  logic              better_q, better_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] window_sad;
  logic              complete;

  assign lanes = {In16_EX4, In15_EX4, In14_EX4, In13_EX4, In12_EX4, In11_EX4, In10_EX4, In9_EX4,
                  In8_EX4,  In7_EX4,  In6_EX4,  In5_EX4,  In4_EX4,  In3_EX4,  In2_EX4,  In1_EX4};

  sad_adder_tree16 #(.DATA_W(DATA_W)) u_stage_a (
    .Clk       (Clk),
    .Reset     (Reset),
    .valid_i   (sad_valid_EX4),
    .start_i   (sad_start_EX4),
    .last_i    (sad_last_EX4),
    .lanes_i   (lanes),
    .outx_i    (outx_EX4),
    .outy_i    (outy_EX4),
    .valid_o   (a_valid),
    .start_o   (a_start),
    .last_o    (a_last),
    .row_sum_o (a_sum),
    .outx_o    (a_outx),
    .outy_o    (a_outy)
  );

  assign window_sad = (a_start ? '0 : acc_q) + a_sum;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    row_count_d = row_count_q;
    sad_out_d   = sad_out_q;
    sad_done_d  = 1'b0;
    better_d    = 1'b0;
    err_d       = err_q;
    complete    = 1'b0;
    // A coincident clear is applied before the completing window is compared.
    min_sad_d   = clear_min ? MIN_INIT : min_sad_q;
    best_x_d    = clear_min ? '0 : best_x_q;
    best_y_d    = clear_min ? '0 : best_y_q;

    if (a_valid) begin
      if (a_start) begin
        if (state_q == ACCUM) err_d = 1'b1;
        if (a_last) begin
          complete = 1'b1;
        end else begin
          acc_d       = a_sum;
          row_count_d = 5'd1;
          state_d     = ACCUM;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (a_last) begin
        complete = 1'b1;
      end else if (row_count_q == ROW_LIMIT) begin
        err_d       = 1'b1;
        state_d     = IDLE;
        row_count_d = '0;
      end else begin
        acc_d       = window_sad;
        row_count_d = row_count_q + 5'd1;
      end
    end

    if (complete) begin
      sad_out_d   = window_sad;
      sad_done_d  = 1'b1;
      state_d     = IDLE;
      row_count_d = '0;
      if (window_sad < min_sad_d) begin
        min_sad_d = window_sad;
        best_x_d  = a_outx;
        best_y_d  = a_outy;
        better_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      row_count_q <= '0;
      sad_out_q   <= '0;
      sad_done_q  <= 1'b0;
      min_sad_q   <= MIN_INIT;
      best_x_q    <= '0;
      best_y_q    <= '0;
      better_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      row_count_q <= row_count_d;
      sad_out_q   <= sad_out_d;
      sad_done_q  <= sad_done_d;
      min_sad_q   <= min_sad_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      better_q    <= better_d;
      err_q       <= err_d;
    end
  end

  assign sad_out      = sad_out_q;
  assign sad_done     = sad_done_q;
  assign min_sad      = min_sad_q;
  assign best_x       = best_x_q;
  assign best_y       = best_y_q;
  assign better       = better_q;
  assign row_count    = row_count_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_sad_min_tracker_ex4.sv
// Directed bench for sad_min_tracker_ex4: a window-level reference model compared every
// cycle, plus literal expectations at the points of interest.
module tb_sad_min_tracker_ex4;

  localparam int MAXR = 16;

  logic        Clk = 1'b0;
  logic        Reset, v, s, l, clr;
  logic [31:0] lane [16];
  logic [31:0] ox, oy;

  logic [31:0] sad_out, min_sad, best_x, best_y;
  logic        sad_done, better, protocol_err;
  logic [4:0]  row_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 Clk = ~Clk;

  sad_min_tracker_ex4 dut (
    .Clk(Clk), .Reset(Reset), .sad_valid_EX4(v), .sad_start_EX4(s), .sad_last_EX4(l),
    .clear_min(clr),
    .In1_EX4(lane[0]),   .In2_EX4(lane[1]),   .In3_EX4(lane[2]),   .In4_EX4(lane[3]),
    .In5_EX4(lane[4]),   .In6_EX4(lane[5]),   .In7_EX4(lane[6]),   .In8_EX4(lane[7]),
    .In9_EX4(lane[8]),   .In10_EX4(lane[9]),  .In11_EX4(lane[10]), .In12_EX4(lane[11]),
    .In13_EX4(lane[12]), .In14_EX4(lane[13]), .In15_EX4(lane[14]), .In16_EX4(lane[15]),
    .outx_EX4(ox), .outy_EX4(oy),
    .sad_out(sad_out), .sad_done(sad_done), .min_sad(min_sad), .best_x(best_x),
    .best_y(best_y), .better(better), .row_count(row_count), .protocol_err(protocol_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rows of the open window kept as a list, outputs derived per window.
  logic [31:0] rows [$];
  bit          active;
  logic [31:0] m_sad, m_min, m_bx, m_by, m_rc;
  bit          m_done, m_better, m_err;
  bit          pa_valid, pa_start, pa_last;
  logic [31:0] pa_sum, pa_x, pa_y, cur_sum, total;
  bit          finish;

  always @(posedge Clk) begin
    cur_sum = 0;
    for (int i = 0; i < 16; i++) cur_sum += lane[i];
    if (Reset) begin
      m_sad = 0; m_done = 0; m_min = '1; m_bx = 0; m_by = 0; m_better = 0; m_err = 0;
      rows.delete(); active = 0;
      pa_valid = 0; pa_start = 0; pa_last = 0; pa_sum = 0; pa_x = 0; pa_y = 0;
    end else begin
      m_done = 0; m_better = 0; finish = 0;
      if (clr) begin m_min = '1; m_bx = 0; m_by = 0; end
      if (pa_valid) begin
        if (pa_start) begin
          if (active) m_err = 1;
          rows.delete();
          rows.push_back(pa_sum);
          active = 1;
          finish = pa_last;
        end else if (!active) begin
          m_err = 1;
        end else begin
          rows.push_back(pa_sum);
          if (pa_last) finish = 1;
          else if (rows.size() > MAXR) begin
            m_err = 1; rows.delete(); active = 0;
          end
        end
        if (finish) begin
          total = 0;
          foreach (rows[k]) total += rows[k];
          m_sad = total; m_done = 1;
          if (total < m_min) begin m_min = total; m_bx = pa_x; m_by = pa_y; m_better = 1; end
          rows.delete(); active = 0;
        end
      end
      pa_valid = v; pa_start = s; pa_last = l; pa_sum = cur_sum; pa_x = ox; pa_y = oy;
    end
    m_rc = active ? 32'(rows.size()) : 32'd0;
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("m_sad_out", sad_out, m_sad);
      check("m_sad_done", 32'(sad_done), 32'(m_done));
      check("m_min_sad", min_sad, m_min);
      check("m_best_x", best_x, m_bx);
      check("m_best_y", best_y, m_by);
      check("m_better", 32'(better), 32'(m_better));
      check("m_row_count", 32'(row_count), m_rc);
      check("m_protocol_err", 32'(protocol_err), 32'(m_err));
    end
  end

  // Lane i = base + i*step, lane 0 additionally gets bonus: row sum = 16*base + 120*step + bonus.
  task automatic row(input logic st, input logic ls, input int unsigned base, input int unsigned step,
                     input int unsigned bonus, input logic [31:0] x, input logic [31:0] y);
    v = 1'b1; s = st; l = ls; ox = x; oy = y; clr = 1'b0;
    for (int i = 0; i < 16; i++) lane[i] = base + i * step + ((i == 0) ? bonus : 0);
    $display("row start=%0b last=%0b sum=%0d xy=(%0d,%0d) t=%0t", st, ls,
             16 * base + 120 * step + bonus, x, y, $time);
    @(negedge Clk);
  endtask

  task automatic idle(input int n, input logic c);
    v = 1'b0; s = 1'b0; l = 1'b0; clr = c;
    repeat (n) @(negedge Clk);
    clr = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; v = 0; s = 0; l = 0; clr = 0; ox = 0; oy = 0;
    for (int i = 0; i < 16; i++) lane[i] = 0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    cmp_en = 1'b1;
    check("rst_min_sad", min_sad, 32'hFFFF_FFFF);
    check("rst_sad_out", sad_out, 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);

    // single-row window
    row(1, 1, 5, 0, 0, 3, 7);
    idle(1, 0);
    check("single_sad", sad_out, 32'd80);
    check("single_done", 32'(sad_done), 32'd1);
    check("single_min", min_sad, 32'd80);
    check("single_bx", best_x, 32'd3);
    check("single_by", best_y, 32'd7);
    check("single_better", 32'(better), 32'd1);

    // four-row window 160, then a tying window at (9,9)
    idle(1, 1);
    row(1, 0, 1, 0, 0, 4, 4); row(0, 0, 2, 0, 0, 4, 4);
    row(0, 0, 3, 0, 0, 4, 4); row(0, 1, 4, 0, 0, 4, 4);
    idle(1, 0);
    check("four_sad", sad_out, 32'd160);
    check("four_better", 32'(better), 32'd1);
    row(1, 0, 1, 0, 0, 9, 9); row(0, 0, 2, 0, 0, 9, 9);
    row(0, 0, 3, 0, 0, 9, 9); row(0, 1, 4, 0, 0, 9, 9);
    idle(1, 0);
    check("tie_sad", sad_out, 32'd160);
    check("tie_done", 32'(sad_done), 32'd1);
    check("tie_better", 32'(better), 32'd0);
    check("tie_bx", best_x, 32'd4);

    // back-to-back windows 200 then 150
    row(1, 0, 5, 0, 0, 20, 21); row(0, 1, 0, 1, 0, 20, 21);
    row(1, 1, 1, 1, 14, 30, 31);
    check("b2b_first_sad", sad_out, 32'd200);
    check("b2b_first_done", 32'(sad_done), 32'd1);
    idle(1, 0);
    check("b2b_second_sad", sad_out, 32'd150);
    check("b2b_second_done", 32'(sad_done), 32'd1);
    check("b2b_min", min_sad, 32'd150);
    check("b2b_bx", best_x, 32'd30);

    // continuation row in IDLE, then start mid-window
    row(0, 0, 1, 0, 0, 0, 0);
    idle(1, 0);
    check("idle_cont_err", 32'(protocol_err), 32'd1);
    check("idle_cont_done", 32'(sad_done), 32'd0);
    row(1, 0, 7, 0, 0, 40, 41); row(1, 0, 2, 0, 0, 40, 41); row(0, 1, 1, 0, 0, 40, 41);
    idle(1, 0);
    check("restart_sad", sad_out, 32'd48);
    check("restart_min", min_sad, 32'd48);

    // clear_min coinciding with completion of a 500 window, old min 10
    idle(1, 1);
    row(1, 1, 0, 0, 10, 1, 2);
    idle(1, 0);
    check("min10", min_sad, 32'd10);
    row(1, 1, 10, 2, 100, 50, 51);
    idle(1, 1);
    check("clr_sad", sad_out, 32'd500);
    check("clr_min", min_sad, 32'd500);
    check("clr_better", 32'(better), 32'd1);
    check("clr_by", best_y, 32'd51);

    // reset mid-window, then a fresh window
    row(1, 0, 2, 0, 0, 8, 8); row(0, 0, 2, 0, 0, 8, 8);
    Reset = 1'b1;
    idle(1, 0);
    Reset = 1'b0;
    check("rst2_sad", sad_out, 32'd0);
    check("rst2_min", min_sad, 32'hFFFF_FFFF);
    check("rst2_err", 32'(protocol_err), 32'd0);
    check("rst2_rc", 32'(row_count), 32'd0);
    row(1, 1, 3, 0, 0, 5, 6);
    idle(1, 0);
    check("post_rst_sad", sad_out, 32'd48);
    check("post_rst_bx", best_x, 32'd5);

    // 17 rows without last: the 17th is dropped and flagged
    row(1, 0, 1, 0, 0, 0, 0);
    for (int r = 0; r < 16; r++) row(0, 0, 1, 0, 0, 0, 0);
    idle(1, 0);
    check("ovf_err", 32'(protocol_err), 32'd1);
    check("ovf_rc", 32'(row_count), 32'd0);
    row(0, 1, 1, 0, 0, 0, 0);
    idle(1, 0);
    check("ovf_last_done", 32'(sad_done), 32'd0);

    // row sum wraps modulo 2^32
    row(1, 1, 32'h1000_0000, 0, 0, 7, 8);
    idle(1, 0);
    check("wrap_sad", sad_out, 32'd0);
    check("wrap_min", min_sad, 32'd0);

    idle(2, 0);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
